// File: rtl/cordic_chan_sched.sv
// cordic_chan_sched
//   Round-robin scheduler sharing one fully pipelined CORDIC among NCH
//   requesters. One phase request is accepted per enabled cycle, launched
//   through a registered phase, tracked by a tag/valid shift register of
//   LAT+1 stages, and returned to the originating channel's output register.
//
// Ports
//   i_clk, i_reset   clock, synchronous active-high reset
//   i_en             global enable; low freezes scheduler and CORDIC
//   i_req_valid      per-channel request valid
//   i_req_phase      per-channel phase, channel k at [k*PW +: PW]
//   o_req_ready      one-hot grant (combinational)
//   o_cor_ce         CORDIC clock enable (equals i_en)
//   o_cor_phase      registered phase to the CORDIC
//   i_cor_x/i_cor_y  rounded CORDIC outputs
//   o_valid          one-cycle per-channel result strobe
//   o_x/o_y          per-channel result registers, channel k at [k*OW +: OW]
//   o_inflight       launches not yet returned
module cordic_chan_sched #(
  parameter int NCH = 4,
  parameter int PW  = 16,
  parameter int OW  = 12,
  parameter int LAT = 18
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_en,
  input  logic [NCH-1:0]              i_req_valid,
  input  logic [NCH*PW-1:0]           i_req_phase,
  output logic [NCH-1:0]              o_req_ready,
  output logic                        o_cor_ce,
  output logic [PW-1:0]               o_cor_phase,
  input  logic [OW-1:0]               i_cor_x,
  input  logic [OW-1:0]               i_cor_y,
  output logic [NCH-1:0]              o_valid,
  output logic [NCH*OW-1:0]           o_x,
  output logic [NCH*OW-1:0]           o_y,
  output logic [$clog2(LAT+2)-1:0]    o_inflight
);

  localparam int TW = $clog2(NCH);
  localparam int IW = $clog2(LAT + 2);

  logic [TW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     phase_q, phase_d;
  logic [LAT:0]      vld_q, vld_d;
  logic [TW-1:0]     tag_q [LAT+1];
  logic [TW-1:0]     tag_d [LAT+1];
  logic [NCH-1:0]    ovalid_q, ovalid_d;
  logic [NCH*OW-1:0] x_q, x_d, y_q, y_d;
  logic [IW-1:0]     infl_q, infl_d;

  logic [NCH-1:0]    grant;
  logic [TW-1:0]     gidx;
  logic              xfer;
  logic              ret;
  logic [TW:0]       cand;

  // Rotating-priority search: candidate = (ptr + i) mod NCH, first valid wins.
  always_comb begin
    grant = '0;
    gidx  = '0;
    xfer  = 1'b0;
    cand  = '0;
    if (i_en && !i_reset) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        cand = {1'b0, ptr_q} + (TW+1)'(i);
        if (cand >= (TW+1)'(NCH)) begin
          cand = cand - (TW+1)'(NCH);
        end
        if (!xfer && i_req_valid[cand[TW-1:0]]) begin
          xfer = 1'b1;
          gidx = cand[TW-1:0];
        end
      end
    end
    if (xfer) begin
      grant = NCH'(1) << gidx;
    end
  end

  always_comb begin
    ptr_d    = ptr_q;
    phase_d  = phase_q;
    vld_d    = vld_q;
    tag_d    = tag_q;
    ovalid_d = ovalid_q;
    x_d      = x_q;
    y_d      = y_q;
    infl_d   = infl_q;
    ret      = 1'b0;
    if (i_en) begin
      ret      = vld_q[LAT];
      vld_d    = {vld_q[LAT-1:0], xfer};
      tag_d[0] = gidx;
      for (int unsigned i = 1; i <= LAT; i++) begin
        tag_d[i] = tag_q[i-1];
      end
      ovalid_d = '0;
      if (xfer) begin
        phase_d = i_req_phase[gidx*PW +: PW];
        ptr_d   = (gidx == TW'(NCH - 1)) ? '0 : gidx + 1'b1;
      end
      if (ret) begin
        ovalid_d[tag_q[LAT]]        = 1'b1;
        x_d[tag_q[LAT]*OW +: OW]    = i_cor_x;
        y_d[tag_q[LAT]*OW +: OW]    = i_cor_y;
      end
      if (xfer && !ret) begin
        infl_d = infl_q + 1'b1;
      end else if (!xfer && ret) begin
        infl_d = infl_q - 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ptr_q    <= '0;
      phase_q  <= '0;
      vld_q    <= '0;
      ovalid_q <= '0;
      x_q      <= '0;
      y_q      <= '0;
      infl_q   <= '0;
    end else begin
      ptr_q    <= ptr_d;
      phase_q  <= phase_d;
      vld_q    <= vld_d;
      ovalid_q <= ovalid_d;
      x_q      <= x_d;
      y_q      <= y_d;
      infl_q   <= infl_d;
    end
  end

  // Tags are qualified by vld_q, so they need no reset.
  always_ff @(posedge i_clk) begin
    tag_q <= tag_d;
  end

  assign o_req_ready = grant;
  assign o_cor_ce    = i_en;
  assign o_cor_phase = phase_q;
  // The strobe register freezes while disabled; masking it here makes a
  // pending strobe appear on the next enabled cycle instead of being lost.
  assign o_valid     = i_en ? ovalid_q : '0;
  assign o_x         = x_q;
  assign o_y         = y_q;
  assign o_inflight  = infl_q;

endmodule

// File: tb/tb_cordic_chan_sched.sv
module tb_cordic_chan_sched;
  localparam int NCH = 4;
  localparam int PW  = 16;
  localparam int OW  = 12;
  localparam int LAT = 18;
  localparam int IW  = $clog2(LAT + 2);

  logic              clk = 1'b0;
  logic              i_reset, i_en;
  logic [NCH-1:0]    i_req_valid;
  logic [NCH*PW-1:0] i_req_phase;
  logic [NCH-1:0]    o_req_ready;
  logic              o_cor_ce;
  logic [PW-1:0]     o_cor_phase;
  logic [OW-1:0]     i_cor_x, i_cor_y;
  logic [NCH-1:0]    o_valid;
  logic [NCH*OW-1:0] o_x, o_y;
  logic [IW-1:0]     o_inflight;

  always #5 clk = ~clk;

  cordic_chan_sched #(.NCH(NCH), .PW(PW), .OW(OW), .LAT(LAT)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_en(i_en),
    .i_req_valid(i_req_valid), .i_req_phase(i_req_phase),
    .o_req_ready(o_req_ready), .o_cor_ce(o_cor_ce), .o_cor_phase(o_cor_phase),
    .i_cor_x(i_cor_x), .i_cor_y(i_cor_y),
    .o_valid(o_valid), .o_x(o_x), .o_y(o_y), .o_inflight(o_inflight)
  );

  // CORDIC stand-in: LAT-stage delay line, x = phase[11:0], y = phase[15:4]^0x3FF.
  // Never reset, so stale results keep emerging after a DUT reset.
  function automatic logic [OW-1:0] exp_x(input logic [PW-1:0] p);
    return p[11:0];
  endfunction
  function automatic logic [OW-1:0] exp_y(input logic [PW-1:0] p);
    return p[15:4] ^ 12'h3FF;
  endfunction

  logic [PW-1:0] cm [LAT];
  initial for (int i = 0; i < LAT; i++) cm[i] = '0;
  always @(posedge clk) if (o_cor_ce) begin
    cm[0] <= o_cor_phase;
    for (int i = 1; i < LAT; i++) cm[i] <= cm[i-1];
  end
  assign i_cor_x = exp_x(cm[LAT-1]);
  assign i_cor_y = exp_y(cm[LAT-1]);

  typedef struct {
    logic [OW-1:0] x;
    logic [OW-1:0] y;
    int unsigned   due;
  } exp_t;

  exp_t          sb [NCH][$];
  logic [PW-1:0] src_q [NCH][$];
  int unsigned   pulses [NCH];
  int unsigned   gcnt [NCH];
  int unsigned   glog [$];
  int            total = 0;
  int            bad = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Requester driver: holds valid/phase until the handshake, then advances.
  initial begin : src
    logic [NCH-1:0] xf;
    i_req_valid = '0;
    i_req_phase = '0;
    forever begin
      @(negedge clk);
      xf = i_req_valid & o_req_ready;
      @(posedge clk); #2;
      for (int ch = 0; ch < NCH; ch++) begin
        if (xf[ch] && src_q[ch].size() != 0) void'(src_q[ch].pop_front());
        i_req_valid[ch] = (src_q[ch].size() != 0);
        i_req_phase[ch*PW +: PW] = (src_q[ch].size() != 0) ? src_q[ch][0] : '0;
      end
    end
  end

  // Issue side: predicts the grant, and on each transfer pushes the expected
  // result with its due enabled-cycle index (transfer + LAT + 2).
  initial begin : issue
    int unsigned en_n, eptr, c, g;
    logic found;
    logic [NCH-1:0] expg;
    logic [PW-1:0] ph;
    exp_t e;
    en_n = 0;
    eptr = 0;
    forever begin
      @(negedge clk);
      if (i_en) en_n++;
      expg = '0;
      found = 1'b0;
      g = 0;
      if (i_en && !i_reset) begin
        for (int unsigned k = 0; k < NCH; k++) begin
          c = (eptr + k) % NCH;
          if (!found && i_req_valid[c]) begin
            found = 1'b1;
            g = c;
          end
        end
      end
      if (found) expg[g] = 1'b1;
      check("grant", 64'(o_req_ready), 64'(expg));
      check("cor_ce", 64'(o_cor_ce), 64'(i_en));
      for (int unsigned k = 0; k < NCH; k++) begin
        if (o_req_ready[k]) begin
          gcnt[k]++;
          glog.push_back(k);
        end
      end
      if (found) begin
        ph = i_req_phase[g*PW +: PW];
        e.x = exp_x(ph);
        e.y = exp_y(ph);
        e.due = en_n + LAT + 2;
        sb[g].push_back(e);
        eptr = (g + 1) % NCH;
      end
      if (i_reset) eptr = 0;
    end
  end

  // Monitor: pops and compares whenever a channel strobes o_valid.
  initial begin : monitor
    int unsigned en_m;
    exp_t e;
    en_m = 0;
    forever begin
      @(negedge clk);
      if (i_en) en_m++;
      if (!i_en) check("valid_gated", 64'(o_valid), 64'd0);
      for (int ch = 0; ch < NCH; ch++) begin
        if (o_valid[ch]) begin
          pulses[ch]++;
          if (sb[ch].size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_valid: ch=%0d got strobe expected none at %0t", ch, $time);
          end else begin
            e = sb[ch].pop_front();
            check("res_x", 64'(o_x[ch*OW +: OW]), 64'(e.x));
            check("res_y", 64'(o_y[ch*OW +: OW]), 64'(e.y));
            check("res_cycle", 64'(en_m), 64'(e.due));
          end
        end
      end
      if (i_reset) for (int ch = 0; ch < NCH; ch++) sb[ch].delete();
    end
  end

  function automatic logic all_idle();
    logic r = 1'b1;
    for (int ch = 0; ch < NCH; ch++)
      if (src_q[ch].size() != 0 || sb[ch].size() != 0) r = 1'b0;
    return r;
  endfunction

  task automatic drain(input string nm);
    logic done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      tick();
      done = all_idle() && (o_inflight == '0) && (o_valid == '0);
    end
    check(nm, 64'(done), 64'd1);
  endtask

  task automatic clr_counts();
    for (int ch = 0; ch < NCH; ch++) begin
      pulses[ch] = 0;
      gcnt[ch] = 0;
    end
    glog.delete();
  endtask

  initial begin : main
    logic got;
    int unsigned mx;
    i_reset = 1'b1;
    i_en = 1'b1;
    clr_counts();
    tick(3);
    // Reset state
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_x", 64'(o_x), 64'd0);
    check("rst_y", 64'(o_y), 64'd0);
    check("rst_inflight", 64'(o_inflight), 64'd0);
    check("rst_phase", 64'(o_cor_phase), 64'd0);
    i_reset = 1'b0;
    tick(2);

    // Single request: channel 2, phase 0x4000 -> (0x000, 0x7FF) after LAT+2
    src_q[2].push_back(16'h4000);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = (o_req_ready != '0);
    end
    check("t1_ready", 64'(o_req_ready), 64'b0100);
    for (int i = 1; i <= 19; i++) begin
      tick();
      check("t1_inflight", 64'(o_inflight), 64'd1);
    end
    tick();
    check("t1_valid", 64'(o_valid), 64'b0100);
    check("t1_y", 64'(o_y[2*OW +: OW]), 64'h7FF);
    check("t1_x", 64'(o_x[2*OW +: OW]), 64'h000);
    check("t1_other_y", 64'(o_y[0 +: OW]), 64'h000);
    check("t1_inflight_done", 64'(o_inflight), 64'd0);
    tick();
    check("t1_strobe_once", 64'(o_valid), 64'd0);
    check("t1_hold_y", 64'(o_y[2*OW +: OW]), 64'h7FF);

    // Round robin: all four channels valid from reset release
    i_reset = 1'b1;
    for (int ch = 0; ch < NCH; ch++)
      for (int n = 0; n < 12; n++) src_q[ch].push_back(16'(16'h0100 * (ch + 1) + n * 16'h0011));
    tick(2);
    clr_counts();
    i_reset = 1'b0;
    drain("rr_drain");
    begin
      int unsigned ord [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
      for (int i = 0; i < 8; i++) check("rr_order", 64'(glog[i]), 64'(ord[i]));
    end
    for (int ch = 0; ch < NCH; ch++) begin
      check("rr_grants", 64'(gcnt[ch]), 64'd12);
      check("rr_pulses", 64'(pulses[ch]), 64'd12);
    end

    // Streaming: channel 1 alone, 50 back-to-back requests
    clr_counts();
    for (int n = 0; n < 50; n++) src_q[1].push_back(16'(16'h2000 + n));
    mx = 0;
    for (int i = 0; i < 120; i++) begin
      tick();
      if (o_inflight > mx) mx = o_inflight;
    end
    drain("stream_drain");
    check("stream_max_inflight", 64'(mx), 64'd19);
    check("stream_pulses", 64'(pulses[1]), 64'd50);
    check("stream_grants", 64'(gcnt[1]), 64'd50);

    // Enable stall: 3 in flight, i_en low for 5 cycles
    clr_counts();
    src_q[0].push_back(16'h1234);
    src_q[1].push_back(16'h5678);
    src_q[2].push_back(16'h9ABC);
    tick(3);
    check("stall_pre_inflight", 64'(o_inflight), 64'd3);
    i_en = 1'b0;
    src_q[3].push_back(16'hDEF0);
    for (int i = 0; i < 5; i++) begin
      check("stall_inflight", 64'(o_inflight), 64'd3);
      check("stall_valid", 64'(o_valid), 64'd0);
      tick();
    end
    i_en = 1'b1;
    drain("stall_drain");
    check("stall_pulses3", 64'(pulses[3]), 64'd1);

    // Reset mid-flight: 3 in flight, results must be discarded
    clr_counts();
    src_q[0].push_back(16'h0F0F);
    src_q[1].push_back(16'h7777);
    src_q[2].push_back(16'h3C3C);
    tick(3);
    check("rmf_pre_inflight", 64'(o_inflight), 64'd3);
    i_reset = 1'b1;
    tick();
    check("rmf_inflight", 64'(o_inflight), 64'd0);
    check("rmf_valid", 64'(o_valid), 64'd0);
    check("rmf_x", 64'(o_x), 64'd0);
    check("rmf_y", 64'(o_y), 64'd0);
    check("rmf_phase", 64'(o_cor_phase), 64'd0);
    i_reset = 1'b0;
    tick(25);
    check("rmf_no_pulses", 64'(pulses[0] + pulses[1] + pulses[2]), 64'd0);
    src_q[3].push_back(16'hAAAA);
    src_q[1].push_back(16'h5555);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = (o_req_ready != '0);
    end
    check("rmf_ptr_zero", 64'(o_req_ready), 64'b0010);
    drain("rmf_drain");

    // Simultaneous launch and return: two channels keep the pipe full
    for (int n = 0; n < 30; n++) begin
      src_q[0].push_back(16'(16'h4100 + n));
      src_q[2].push_back(16'(16'h8200 + n));
    end
    tick(22);
    for (int i = 0; i < 15; i++) begin
      check("sim_inflight", 64'(o_inflight), 64'd19);
      tick();
    end
    drain("sim_drain");

    for (int ch = 0; ch < NCH; ch++) check("sb_empty", 64'(sb[ch].size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
